// File: rtl/m_issue_scoreboard_if.sv
// Issue-port bundle between decode and the issue scoreboard.
// Handshake: an instruction transfers on a cycle where in_valid & in_ready are both 1;
// out_valid mirrors that transfer to execute and never depends on out_ready.
interface m_issue_scoreboard_if #(
  parameter int NUM_REGS = 32
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic                in_valid;
  logic                in_ready;
  logic [SEL_W-1:0]    rs_sel;
  logic [SEL_W-1:0]    rq_sel;
  logic                uses_rs;
  logic                uses_rq;
  logic [SEL_W-1:0]    rd_sel;
  logic                writes_rd;
  logic                out_valid;
  logic                out_ready;
  logic                wb_valid;
  logic [SEL_W-1:0]    wb_rd;
  logic                drain_req;
  logic                drain_ack;
  logic [NUM_REGS-1:0] pending;
  logic [3:0]          outstanding;
  logic [15:0]         stall_cycles;
  logic [1:0]          fsm_state;

  modport master (
    output in_valid, rs_sel, rq_sel, uses_rs, uses_rq, rd_sel, writes_rd,
           out_ready, wb_valid, wb_rd, drain_req,
    input  in_ready, out_valid, drain_ack, pending, outstanding, stall_cycles, fsm_state
  );

  modport slave (
    input  in_valid, rs_sel, rq_sel, uses_rs, uses_rq, rd_sel, writes_rd,
           out_ready, wb_valid, wb_rd, drain_req,
    output in_ready, out_valid, drain_ack, pending, outstanding, stall_cycles, fsm_state
  );
endinterface

// File: rtl/m_issue_scoreboard.sv
// Decode-stage issue scoreboard: stalls on RAW/WAW against in-flight writes, caps the
// number of outstanding writers and offers a drain handshake for trap/CSR entry.
module m_issue_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int R0_HARDWIRED    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  m_issue_scoreboard_if.slave   bus
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic [3:0]          r_outstanding;
  logic [3:0]          w_outstanding_nxt;
  logic [15:0]         r_stall_cycles;
  logic                r_drain_ack;

  logic w_r0;
  logic w_rs_hit;
  logic w_rq_hit;
  logic w_rd_hit;
  logic w_hazard;
  logic w_full;
  logic w_run;
  logic w_go;
  logic w_issue;
  logic w_set;
  logic w_clr;
  logic w_stall_inc;

  assign w_r0 = (R0_HARDWIRED != 0);

  // Hazards look only at registered pending bits: a writeback frees dependents next cycle.
  assign w_rs_hit = bus.uses_rs   & r_pending[bus.rs_sel] & ~(w_r0 & (bus.rs_sel == '0));
  assign w_rq_hit = bus.uses_rq   & r_pending[bus.rq_sel] & ~(w_r0 & (bus.rq_sel == '0));
  assign w_rd_hit = bus.writes_rd & r_pending[bus.rd_sel] & ~(w_r0 & (bus.rd_sel == '0));
  assign w_hazard = w_rs_hit | w_rq_hit | w_rd_hit;
  assign w_full   = bus.writes_rd & (r_outstanding == MAX_CNT);
  assign w_run    = (r_state == ST_RUN);
  assign w_go     = rst_n & w_run & ~w_hazard & ~w_full;

  assign bus.out_valid = bus.in_valid & w_go;
  assign bus.in_ready  = bus.out_ready & w_go;
  assign w_issue       = bus.in_valid & bus.in_ready;

  assign w_set       = w_issue & bus.writes_rd & ~(w_r0 & (bus.rd_sel == '0));
  assign w_clr       = bus.wb_valid & r_pending[bus.wb_rd];
  assign w_stall_inc = bus.in_valid & w_run & (w_hazard | w_full);

  // Clear before set so a same-register set survives; the count only moves when one side acts.
  always_comb begin
    w_pending_nxt     = r_pending;
    w_outstanding_nxt = r_outstanding;
    if (w_clr) w_pending_nxt[bus.wb_rd]  = 1'b0;
    if (w_set) w_pending_nxt[bus.rd_sel] = 1'b1;
    if (w_set && !w_clr)      w_outstanding_nxt = r_outstanding + 4'd1;
    else if (w_clr && !w_set) w_outstanding_nxt = r_outstanding - 4'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (bus.drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.drain_req)            w_state_nxt = ST_RUN;
        else if (r_outstanding == '0)  w_state_nxt = ST_DRAINED;
      end
      ST_DRAINED: if (!bus.drain_req) w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_pending      <= '0;
      r_outstanding  <= '0;
      r_stall_cycles <= '0;
      r_drain_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drain_ack   <= (w_state_nxt == ST_DRAINED);
      if (w_stall_inc && (r_stall_cycles != 16'hffff))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.pending      = r_pending;
  assign bus.outstanding  = r_outstanding;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.drain_ack    = r_drain_ack;
  assign bus.fsm_state    = r_state;
endmodule

// File: tb/tb_m_issue_scoreboard.sv
// Directed bench for m_issue_scoreboard: a vector table for the main sequence plus
// hand-written reset-mid-stall and hardwired-r0 sequences.
module tb_m_issue_scoreboard;
  logic clk;
  logic rst_n;

  m_issue_scoreboard_if #(.NUM_REGS(32)) bus ();
  m_issue_scoreboard_if #(.NUM_REGS(32)) bus0 ();

  m_issue_scoreboard #(.NUM_REGS(32), .MAX_OUTSTANDING(4), .R0_HARDWIRED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  m_issue_scoreboard #(.NUM_REGS(32), .MAX_OUTSTANDING(4), .R0_HARDWIRED(1)) u_dut_r0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] rs;
    logic [4:0] rq;
    logic       urs;
    logic       urq;
    logic [4:0] rd;
    logic       wrd;
    logic       ordy;
    logic       wbv;
    logic [4:0] wbrd;
    logic       drq;
    logic       e_rdy;
    logic       e_ov;
    logic [31:0] e_pend;
    logic [3:0] e_out;
    logic       e_ack;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(input logic iv, input int rs, input int rq, input logic urs,
                              input logic urq, input int rd, input logic wrd, input logic ordy,
                              input logic wbv, input int wbrd, input logic drq, input logic e_rdy,
                              input logic e_ov, input logic [31:0] e_pend, input int e_out,
                              input logic e_ack);
    vec_t v;
    v.iv = iv; v.rs = 5'(rs); v.rq = 5'(rq); v.urs = urs; v.urq = urq;
    v.rd = 5'(rd); v.wrd = wrd; v.ordy = ordy; v.wbv = wbv; v.wbrd = 5'(wbrd); v.drq = drq;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_pend = e_pend; v.e_out = 4'(e_out); v.e_ack = e_ack;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    bus.in_valid  = v.iv;   bus.rs_sel  = v.rs;  bus.rq_sel    = v.rq;
    bus.uses_rs   = v.urs;  bus.uses_rq = v.urq; bus.rd_sel    = v.rd;
    bus.writes_rd = v.wrd;  bus.out_ready = v.ordy;
    bus.wb_valid  = v.wbv;  bus.wb_rd   = v.wbrd; bus.drain_req = v.drq;
  endtask

  task automatic drive0(input logic iv, input int rs, input logic urs, input int rd,
                        input logic wrd);
    bus0.in_valid = iv; bus0.rs_sel = 5'(rs); bus0.rq_sel = 5'd0; bus0.uses_rs = urs;
    bus0.uses_rq = 1'b0; bus0.rd_sel = 5'(rd); bus0.writes_rd = wrd; bus0.out_ready = 1'b1;
    bus0.wb_valid = 1'b0; bus0.wb_rd = 5'd0; bus0.drain_req = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0);

    // back-to-back independent, then writebacks
    tbl.push_back(mk(1,1,2,1,1,3,1,1,0,0,0, 1,1,32'h8,1,0));
    tbl.push_back(mk(1,1,2,1,1,4,1,1,0,0,0, 1,1,32'h18,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,3,0, 1,0,32'h10,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,4,0, 1,0,32'h0,0,0));
    // RAW: dependent stalls, writeback in N releases it in N+1
    tbl.push_back(mk(1,1,2,1,1,5,1,1,0,0,0, 1,1,32'h20,1,0));
    tbl.push_back(mk(1,5,2,1,1,6,1,1,0,0,0, 0,0,32'h20,1,0));
    tbl.push_back(mk(1,5,2,1,1,6,1,1,1,5,0, 0,0,32'h0,0,0));
    tbl.push_back(mk(1,5,2,1,1,6,1,1,0,0,0, 1,1,32'h40,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,6,0, 1,0,32'h0,0,0));
    // full: four writers, fifth stalls, non-writer still issues
    tbl.push_back(mk(1,0,0,0,0,1,1,1,0,0,0, 1,1,32'h2,1,0));
    tbl.push_back(mk(1,0,0,0,0,2,1,1,0,0,0, 1,1,32'h6,2,0));
    tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 1,1,32'he,3,0));
    tbl.push_back(mk(1,0,0,0,0,4,1,1,0,0,0, 1,1,32'h1e,4,0));
    tbl.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 0,0,32'h1e,4,0));
    tbl.push_back(mk(1,8,9,1,1,7,0,1,0,0,0, 1,1,32'h1e,4,0));
    tbl.push_back(mk(1,0,0,0,0,7,1,1,1,1,0, 0,0,32'h1c,3,0));
    tbl.push_back(mk(1,0,0,0,0,7,1,1,0,0,0, 1,1,32'h9c,4,0));
    // out_valid independent of out_ready
    tbl.push_back(mk(1,8,9,1,1,0,0,0,0,0,0, 0,1,32'h9c,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,2,0, 1,0,32'h98,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,3,0, 1,0,32'h90,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,4,0, 1,0,32'h80,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,7,0, 1,0,32'h0,0,0));
    // same-register writer vs writeback (WAW stall), different-register concurrent, spurious wb
    tbl.push_back(mk(1,0,0,0,0,9,1,1,0,0,0, 1,1,32'h200,1,0));
    tbl.push_back(mk(1,0,0,0,0,9,1,1,1,9,0, 0,0,32'h0,0,0));
    tbl.push_back(mk(1,0,0,0,0,9,1,1,0,0,0, 1,1,32'h200,1,0));
    tbl.push_back(mk(1,0,0,0,0,10,1,1,1,9,0, 1,1,32'h400,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,12,0, 1,0,32'h400,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,10,0, 1,0,32'h0,0,0));
    // drain
    tbl.push_back(mk(1,0,0,0,0,1,1,1,0,0,0, 1,1,32'h2,1,0));
    tbl.push_back(mk(1,0,0,0,0,2,1,1,0,0,0, 1,1,32'h6,2,0));
    tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0,1, 1,1,32'he,3,0));
    tbl.push_back(mk(1,0,0,0,0,4,1,1,0,0,1, 0,0,32'he,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,1,1, 0,0,32'hc,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,2,1, 0,0,32'h8,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,3,1, 0,0,32'h0,0,0));
    tbl.push_back(mk(1,0,0,0,0,4,1,1,0,0,1, 0,0,32'h0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,1, 0,0,32'h0,0,1));
    tbl.push_back(mk(1,0,0,0,0,4,1,1,0,0,0, 0,0,32'h0,0,0));
    tbl.push_back(mk(1,0,0,0,0,4,1,1,0,0,0, 1,1,32'h10,1,0));
    // drain_req dropped while in DRAIN
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,1, 1,0,32'h10,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0, 0,0,32'h10,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,4,0, 1,0,32'h0,0,0));
    // r0 is an ordinary register when not hardwired
    tbl.push_back(mk(1,0,0,0,0,0,1,1,0,0,0, 1,1,32'h1,1,0));
    tbl.push_back(mk(1,0,0,1,0,0,0,1,0,0,0, 0,0,32'h1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,0,0, 1,0,32'h0,0,0));

    rst_n = 1'b0;
    drive(idle);
    drive0(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset pending", bus.pending, 32'h0);
    chk("reset outstanding", 32'(bus.outstanding), 32'd0);
    chk("reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("reset drain_ack", 32'(bus.drain_ack), 32'd0);
    chk("reset fsm_state", 32'(bus.fsm_state), 32'd0);
    drive(mk(1,1,2,1,1,3,1,1,0,0,0, 0,0,0,0,0));
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    drive(idle);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      exp_q.push_back(tbl[i].e_pend);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pending", i), bus.pending, exp_q.pop_front());
      chk($sformatf("v%0d outstanding", i), 32'(bus.outstanding), 32'(tbl[i].e_out));
      chk($sformatf("v%0d drain_ack", i), 32'(bus.drain_ack), 32'(tbl[i].e_ack));
    end
    chk("stall_cycles after table", 32'(bus.stall_cycles), 32'd6);

    // reset asserted while a dependent instruction is stalled
    drive(mk(1,1,2,1,1,5,1,1,0,0,0, 0,0,0,0,0));
    tick();
    drive(mk(1,5,2,1,1,6,1,1,0,0,0, 0,0,0,0,0));
    #1;
    chk("pre-reset hazard in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("pre-reset stall_cycles", 32'(bus.stall_cycles), 32'd7);
    rst_n = 1'b0;
    drive(mk(1,1,2,1,1,8,1,1,0,0,0, 0,0,0,0,0));
    #1;
    chk("in reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("in reset out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("mid reset pending", bus.pending, 32'h0);
    chk("mid reset outstanding", 32'(bus.outstanding), 32'd0);
    chk("mid reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("mid reset drain_ack", 32'(bus.drain_ack), 32'd0);
    rst_n = 1'b1;
    drive(mk(0,0,0,0,0,0,0,1,1,5,0, 0,0,0,0,0));
    tick();
    chk("late wb pending", bus.pending, 32'h0);
    chk("late wb outstanding", 32'(bus.outstanding), 32'd0);
    drive(mk(1,5,2,1,1,6,0,1,0,0,0, 0,0,0,0,0));
    #1;
    chk("post-reset reader in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(idle);

    // hardwired r0 instance
    drive0(1, 1, 1, 0, 1);
    #1;
    chk("r0 writer in_ready", 32'(bus0.in_ready), 32'd1);
    chk("r0 writer out_valid", 32'(bus0.out_valid), 32'd1);
    tick();
    chk("r0 pending", bus0.pending, 32'h0);
    chk("r0 outstanding", 32'(bus0.outstanding), 32'd0);
    drive0(1, 0, 1, 0, 1);
    #1;
    chk("r0 reader in_ready", 32'(bus0.in_ready), 32'd1);
    tick();
    chk("r0 pending after reader", bus0.pending, 32'h0);
    chk("r0 stall_cycles", 32'(bus0.stall_cycles), 32'd0);
    drive0(0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
